// File: rtl/clcd_ctrl.sv
// HD44780 16x2 character LCD sequencer: power-up wait, fixed init sequence, then
// single-byte host writes with generated E strobe and per-command execution waits.
module clcd_ctrl #(
  parameter int unsigned E_PULSE_CYC    = 25,
  parameter int unsigned CMD_WAIT_CYC   = 2000,
  parameter int unsigned CLR_WAIT_CYC   = 82000,
  parameter int unsigned PWRUP_WAIT_CYC = 750000
) (
  input  logic       clk,
  input  logic       nRESET,
  input  logic       req,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       busy,
  output logic       done,
  output logic       init_done,
  output logic       CLCD_RS,
  output logic       CLCD_RW,
  output logic       CLCD_E,
  output logic [7:0] CLCD_DQ
);

  typedef enum logic [2:0] {
    StPwrup, StLoad, StSetup, StEhigh, StHold, StWait, StDone, StIdle
  } state_e;

  localparam logic [19:0] EPulseLd = 20'(E_PULSE_CYC - 1);
  localparam logic [19:0] CmdLd    = 20'(CMD_WAIT_CYC - 1);
  localparam logic [19:0] ClrLd    = 20'(CLR_WAIT_CYC - 1);
  localparam logic [19:0] PwrupLd  = 20'(PWRUP_WAIT_CYC - 1);
  localparam logic [2:0]  LastIdx  = 3'd4;

  function automatic logic [7:0] init_rom(input logic [2:0] idx);
    logic [7:0] val;
    case (idx)
      3'd0:    val = 8'h38;
      3'd1:    val = 8'h38;
      3'd2:    val = 8'h0C;
      3'd3:    val = 8'h01;
      3'd4:    val = 8'h06;
      default: val = 8'h00;
    endcase
    return val;
  endfunction

  state_e      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic        rs_q, rs_d;
  logic [7:0]  dq_q, dq_d;
  logic        e_q, e_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        init_done_q, init_done_d;
  logic        cnt_zero;
  logic        long_wait;

  assign cnt_zero  = (cnt_q == 20'd0);
  // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
  assign long_wait = !rs_q && (dq_q[7:1] <= 7'd1);

  // During init, LOAD already presents RS/DQ one cycle ahead and WAIT follows HOLD
  // with the bus unchanged, so SETUP and HOLD each take a single cycle there.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_zero ? 20'd0 : cnt_q - 20'd1;
    idx_d       = idx_q;
    rs_d        = rs_q;
    dq_d        = dq_q;
    e_d         = e_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    init_done_d = init_done_q;
    unique case (state_q)
      StPwrup: begin
        if (cnt_zero) begin
          state_d = StLoad;
          idx_d   = 3'd0;
          rs_d    = 1'b0;
          dq_d    = init_rom(3'd0);
        end
      end
      StLoad: begin
        state_d = StSetup;
        cnt_d   = 20'd0;
      end
      StSetup: begin
        if (cnt_zero) begin
          state_d = StEhigh;
          e_d     = 1'b1;
          cnt_d   = EPulseLd;
        end
      end
      StEhigh: begin
        if (cnt_zero) begin
          state_d = StHold;
          e_d     = 1'b0;
          cnt_d   = init_done_q ? 20'd1 : 20'd0;
        end
      end
      StHold: begin
        if (cnt_zero) begin
          state_d = StWait;
          cnt_d   = long_wait ? ClrLd : CmdLd;
        end
      end
      StWait: begin
        if (cnt_zero) begin
          if (init_done_q) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else if (idx_q == LastIdx) begin
            state_d     = StIdle;
            init_done_d = 1'b1;
            busy_d      = 1'b0;
          end else begin
            state_d = StLoad;
            idx_d   = idx_q + 3'd1;
            rs_d    = 1'b0;
            dq_d    = init_rom(idx_q + 3'd1);
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
      StIdle: begin
        if (req) begin
          state_d = StSetup;
          rs_d    = req_rs;
          dq_d    = req_data;
          busy_d  = 1'b1;
          cnt_d   = 20'd1;
        end
      end
      default: state_d = StPwrup;
    endcase
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      state_q     <= StPwrup;
      cnt_q       <= PwrupLd;
      idx_q       <= 3'd0;
      rs_q        <= 1'b0;
      dq_q        <= 8'h00;
      e_q         <= 1'b0;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      rs_q        <= rs_d;
      dq_q        <= dq_d;
      e_q         <= e_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      init_done_q <= init_done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign init_done = init_done_q;
  assign CLCD_RS   = rs_q;
  assign CLCD_RW   = 1'b0;
  assign CLCD_E    = e_q;
  assign CLCD_DQ   = dq_q;

endmodule

// File: doc/clcd_ctrl.md
# clcd_ctrl

Sequencer for the 16x2 HD44780-compatible character LCD on the FPGA board (CLCD_RS/RW/E/DQ pins). After reset it runs the LCD power-up wait and fixed initialisation sequence on its own. It then accepts single command/data byte writes from the host interface over a req/busy/done handshake. It generates the E strobe and the per-command execution waits so that software never bit-bangs LCD timing.

## Interface
Parameters:
- E_PULSE_CYC, 25: cycles CLCD_E is held high (500 ns at 50 MHz).
- CMD_WAIT_CYC, 2000: post-strobe wait for ordinary commands and data (40 us).
- CLR_WAIT_CYC, 82000: post-strobe wait for clear/home commands (1.64 ms).
- PWRUP_WAIT_CYC, 750000: wait after reset before the first init command (15 ms). Counter is 20 bits; every parameter must be < 2^20.

Ports:
- clk  in  1  system clock, 50 MHz.
- nRESET  in  1  reset, asynchronous, active-low.
- req  in  1  write request, sampled only in IDLE.
- req_rs  in  1  0 = instruction, 1 = data; latched on accept.
- req_data  in  8  byte to write; latched on accept.
- busy  out  1  high whenever a request would not be accepted.
- done  out  1  one-cycle pulse at completion of a host write.
- init_done  out  1  high once the init sequence has completed; stays high until reset.
- CLCD_RS  out  1  LCD register select.
- CLCD_RW  out  1  LCD read/write; constant 0 (write-only).
- CLCD_E  out  1  LCD enable strobe.
- CLCD_DQ  out  8  LCD data bus.

## Operation
- All outputs are registered.
- Reset values: CLCD_E=0, CLCD_RS=0, CLCD_RW=0, CLCD_DQ=8'h00, busy=1, done=0, init_done=0.
- States: PWRUP, LOAD, SETUP, EHIGH, HOLD, WAIT, DONE, IDLE.
- PWRUP counts PWRUP_WAIT_CYC cycles, then goes to LOAD with init index 0.
- LOAD drives RS=0 and DQ from the init ROM, then goes to SETUP.
- Init ROM, index 0..4: 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06.
- Write cycle: SETUP holds RS/DQ with E=0 for 2 cycles. EHIGH holds E=1 for E_PULSE_CYC cycles. HOLD holds E=0 with RS/DQ unchanged for 2 cycles. WAIT lasts W cycles.
- W = CLR_WAIT_CYC if RS=0 and DQ[7:1]=7'b0000000 (clear) or DQ[7:1]=7'b0000001 (home). Otherwise W = CMD_WAIT_CYC.
- WAIT exit during init: if index<4, increment index and go to LOAD. If index=4, set init_done=1, set busy=0, and go to IDLE. No done pulse is produced during init.
- WAIT exit during a host write: go to DONE.
- DONE asserts done=1 for 1 cycle with busy=1, then goes to IDLE with busy=0 and done=0.
- IDLE with req=1: latch req_rs/req_data onto CLCD_RS/CLCD_DQ, set busy=1, and go to SETUP.
- req while busy=1 is ignored. There is no queueing.
- CLCD_RS/CLCD_DQ keep their last written value while in IDLE.
- Reset asserted mid-operation: immediate return to reset values. After release, PWRUP and the full init sequence rerun.

## Timing
- Accept edge: the clk edge at which state=IDLE and req=1. At that edge busy, CLCD_RS and CLCD_DQ update.
- CLCD_E rises 2 cycles after the accept edge and falls E_PULSE_CYC cycles later.
- done is high in cycle 2+E_PULSE_CYC+2+W+1 after accept. busy falls on the following edge.
- Total busy time per host write: 5+E_PULSE_CYC+W cycles.
- req held continuously high: busy is low for exactly 1 cycle between back-to-back writes.
- RS/DQ are stable for at least 2 cycles before E rises and 2 cycles after E falls.
- Init duration after nRESET release: PWRUP_WAIT_CYC + 5·(3+E_PULSE_CYC) + 4·CMD_WAIT_CYC + CLR_WAIT_CYC cycles. The extra cycle per command is LOAD.
- Counters reload at every state entry. No counter wraps.

## Test plan
Sim parameters: E_PULSE_CYC=4, CMD_WAIT_CYC=20, CLR_WAIT_CYC=50, PWRUP_WAIT_CYC=100.
- Reset release, no requests:
  - CLCD_E pulses 5 times with DQ 38,38,0C,01,06 and RS=0.
  - init_done rises 100+35+80+50=265 cycles after release.
  - done never pulses.
- Host write of req_rs=1, req_data=8'h41 in IDLE:
  - E high for exactly 4 cycles with DQ=41 and RS=1.
  - done pulses in cycle 29 after accept.
  - busy is high for 29 cycles.
- Host write of req_rs=0, req_data=8'h01:
  - done in cycle 59 (clear wait).
  - 8'h02 also takes 59 cycles; 8'h80 takes 29.
- req held high with alternating data 41/42:
  - Back-to-back writes with exactly 1 busy-low cycle between them.
- Pulses on req during init and during a write: all ignored; no extra E strobes.
- nRESET asserted during EHIGH of a host write:
  - CLCD_E=0, busy=1, init_done=0 immediately.
  - After release, the full init sequence repeats with the same counts as the first scenario.
